// File: rtl/fpsr_pkg.sv
// Shared constants for the first-person-second-row status display: state
// encoding, seven-segment glyphs and converter FSM states.
package fpsr_pkg;
  localparam int N_ST        = 18;
  localparam int B_INI       = 0;
  localparam int B_IDLE      = 1;
  localparam int B_GAME      = 2;
  localparam int B_QUIZ      = 3;
  localparam int B_LOSE      = 4;
  localparam int B_WIN       = 5;
  localparam int B_GAME1     = 6;
  localparam int B_GAME2     = 7;
  localparam int B_GAME3     = 8;
  localparam int B_GAME1_S1  = 9;
  localparam int B_GAME2_S1  = 12;
  localparam int B_GAME3_S1  = 15;

  localparam logic [N_ST-1:0] ST_INI   = 18'd1 << B_INI;
  localparam logic [N_ST-1:0] ST_IDLE  = 18'd1 << B_IDLE;
  localparam logic [N_ST-1:0] ST_GAME  = 18'd1 << B_GAME;
  localparam logic [N_ST-1:0] ST_QUIZ  = 18'd1 << B_QUIZ;
  localparam logic [N_ST-1:0] ST_LOSE  = 18'd1 << B_LOSE;
  localparam logic [N_ST-1:0] ST_WIN   = 18'd1 << B_WIN;
  localparam logic [N_ST-1:0] ST_GAME1 = 18'd1 << B_GAME1;
  localparam logic [N_ST-1:0] ST_GAME2 = 18'd1 << B_GAME2;
  localparam logic [N_ST-1:0] ST_GAME3 = 18'd1 << B_GAME3;

  localparam logic [7:0] G_BLANK = 8'hFF;
  localparam logic [7:0] G_DASH  = 8'hBF;
  localparam logic [7:0] G_Q     = 8'h98;
  localparam logic [7:0] G_L     = 8'hC7;
  localparam logic [7:0] G_U     = 8'hC1;
  localparam logic [7:0] G_E     = 8'h86;

  localparam int SCAN_DIV_DEF  = 100000;
  localparam int BLINK_DIV_DEF = 25000000;

  typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_DONE} cv_state_t;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0: digit_glyph = 8'hC0;
      4'd1: digit_glyph = 8'hF9;
      4'd2: digit_glyph = 8'hA4;
      4'd3: digit_glyph = 8'hB0;
      4'd4: digit_glyph = 8'h99;
      4'd5: digit_glyph = 8'h92;
      4'd6: digit_glyph = 8'h82;
      4'd7: digit_glyph = 8'hF8;
      4'd8: digit_glyph = 8'h80;
      4'd9: digit_glyph = 8'h90;
      default: digit_glyph = G_E;
    endcase
  endfunction
endpackage

// File: rtl/fpsr_bin2bcd.sv
// Sequential 8-bit double-dabble: one add-3/shift step per cycle, then a
// single DONE cycle in which the result is valid.
module fpsr_bin2bcd
  import fpsr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [1:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  cv_state_t   cur, nxt;
  logic [17:0] sreg, adj;
  logic [2:0]  cnt;

  always_comb begin
    adj = sreg;
    if (sreg[11:8]  >= 4'd5) adj[11:8]  = sreg[11:8]  + 4'd3;
    if (sreg[15:12] >= 4'd5) adj[15:12] = sreg[15:12] + 4'd3;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      CV_IDLE:  if (start) nxt = CV_SHIFT;
      CV_SHIFT: if (cnt == 3'd7) nxt = CV_DONE;
      default:  nxt = CV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur  <= CV_IDLE;
      sreg <= '0;
      cnt  <= '0;
    end else begin
      cur <= nxt;
      if (cur == CV_IDLE && start) begin
        sreg <= {10'd0, bin};
        cnt  <= '0;
      end else if (cur == CV_SHIFT) begin
        sreg <= {adj[16:0], 1'b0};
        cnt  <= cnt + 3'd1;
      end
    end
  end

  assign busy = (cur != CV_IDLE);
  assign done = (cur == CV_DONE);
  assign hund = sreg[17:16];
  assign tens = sreg[15:12];
  assign ones = sreg[11:8];
endmodule

// File: rtl/fpsr_ssd_status.sv
// Four-digit multiplexed status display: lives, status glyph, minutes tens
// and ones, with a blink overlay while a quiz alert is pending.
module fpsr_ssd_status
  import fpsr_pkg::*;
#(
  parameter int SCAN_DIV  = SCAN_DIV_DEF,
  parameter int BLINK_DIV = BLINK_DIV_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [17:0] state,
  input  logic        professor,
  input  logic [1:0]  game_cnt,
  input  logic [2:0]  lives,
  input  logic [7:0]  minutes,
  output logic [3:0]  An,
  output logic [7:0]  Seg
);
  localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt;
  logic [1:0]    scan_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_on, alert_q, alert;
  logic [7:0]    last_min;
  logic          pending;
  logic          cv_start, cv_busy, cv_done;
  logic [1:0]    cv_hund;
  logic [3:0]    cv_tens, cv_ones, tens, ones;
  logic          hund_flag;
  logic [7:0]    status_g, seg_sel;

  fpsr_bin2bcd u_bcd (
    .clk(Clk), .rst_n(Reset), .start(cv_start), .bin(minutes),
    .busy(cv_busy), .done(cv_done), .hund(cv_hund), .tens(cv_tens), .ones(cv_ones)
  );

  // A change seen while converting is remembered and replayed once idle.
  assign cv_start = !cv_busy && ((minutes != last_min) || pending);
  assign alert    = professor | state[B_QUIZ];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      last_min  <= '0;
      pending   <= 1'b0;
      tens      <= '0;
      ones      <= '0;
      hund_flag <= 1'b0;
    end else begin
      if (cv_start) begin
        last_min <= minutes;
        pending  <= 1'b0;
      end else if (cv_busy && minutes != last_min) begin
        pending  <= 1'b1;
      end
      if (cv_done) begin
        tens      <= cv_tens;
        ones      <= cv_ones;
        hund_flag <= (cv_hund != 2'd0);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      scan_cnt  <= '0;
      scan_idx  <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      alert_q   <= 1'b0;
    end else begin
      if (scan_cnt == SCAN_MAX) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      alert_q <= alert;
      if (!alert || !alert_q) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    status_g = G_E;
    if (!$onehot(state))                                 status_g = G_E;
    else if (state[B_INI])                               status_g = G_BLANK;
    else if (state[B_IDLE])                              status_g = G_DASH;
    else if (state[B_GAME])                              status_g = digit_glyph({2'b00, game_cnt} + 4'd1);
    else if (state[B_QUIZ])                              status_g = G_Q;
    else if (state[B_LOSE])                              status_g = G_L;
    else if (state[B_WIN])                               status_g = G_U;
    else if (state[B_GAME1] || |state[B_GAME1_S1 +: 3]) status_g = digit_glyph(4'd1);
    else if (state[B_GAME2] || |state[B_GAME2_S1 +: 3]) status_g = digit_glyph(4'd2);
    else if (state[B_GAME3] || |state[B_GAME3_S1 +: 3]) status_g = digit_glyph(4'd3);
  end

  always_comb begin
    seg_sel = G_BLANK;
    case (scan_idx)
      2'd0: seg_sel = digit_glyph(ones) & (hund_flag ? 8'h7F : 8'hFF);
      2'd1: seg_sel = digit_glyph(tens);
      2'd2: seg_sel = status_g;
      default: seg_sel = digit_glyph({1'b0, lives});
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      An  <= 4'hF;
      Seg <= 8'hFF;
    end else begin
      An  <= ~(4'b0001 << scan_idx);
      Seg <= blink_on ? seg_sel : G_BLANK;
    end
  end
endmodule

// File: tb/tb_fpsr_ssd_status.sv
// Self-checking bench for fpsr_ssd_status with SCAN_DIV=4, BLINK_DIV=16.
module tb_fpsr_ssd_status;
  localparam int SD = 4;
  localparam int BD = 16;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [17:0] state = '0;
  logic        professor = 1'b0;
  logic [1:0]  game_cnt = '0;
  logic [2:0]  lives = '0;
  logic [7:0]  minutes = '0;
  logic [3:0]  An;
  logic [7:0]  Seg;

  fpsr_ssd_status #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .Clk(Clk), .Reset(Reset), .state(state), .professor(professor),
    .game_cnt(game_cnt), .lives(lives), .minutes(minutes), .An(An), .Seg(Seg)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] d;
    logic [7:0] seg;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [17:0]     st;
    logic [1:0]      gc;
    logic [2:0]      lv;
    logic [7:0]      mn;
    logic [3:0][7:0] e;   // {digit3, digit2, digit1, digit0}
  } vec_t;
  vec_t vt[12];

  function automatic logic [17:0] oh(input int k);
    logic [17:0] one;
    one = 18'd1;
    return one << k;
  endfunction

  function automatic logic [3:0] an_for(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  function automatic int dig_of(input logic [3:0] a);
    case (a)
      4'hE: return 0;
      4'hD: return 1;
      4'hB: return 2;
      4'h7: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain(input string tag);
    exp_t e;
    bit ok;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ok = 1'b0;
      for (int i = 0; i < 4 * SD + 4 && !ok; i++) begin
        tick();
        if (An == an_for(int'(e.d))) ok = 1'b1;
      end
      if (!ok) check($sformatf("%s timeout d%0d", tag, e.d), {4'h0, An}, {4'h0, an_for(int'(e.d))});
      else     check($sformatf("%s d%0d", tag, e.d), Seg, e.seg);
    end
  endtask

  task automatic push4(input logic [3:0][7:0] e);
    for (int d = 0; d < 4; d++) sb.push_back('{d: 2'(d), seg: e[d]});
  endtask

  task automatic steady(input string tag, input logic [3:0][7:0] e, input int n);
    int d;
    for (int j = 0; j < n; j++) begin
      tick();
      d = dig_of(An);
      if (d < 0) check($sformatf("%s an", tag), {4'h0, An}, 8'h0E);
      else       check($sformatf("%s d%0d", tag, d), Seg, e[d]);
    end
  endtask

  task automatic blink_window(input string tag, input logic [3:0][7:0] e);
    int d;
    for (int j = 1; j <= 60; j++) begin
      tick();
      d = dig_of(An);
      if (j >= 20 && j <= 28) check($sformatf("%s off j%0d", tag, j), Seg, 8'hFF);
      if (j >= 36 && j <= 44 && d >= 0) check($sformatf("%s on j%0d", tag, j), Seg, e[d]);
    end
  endtask

  initial begin
    logic [3:0][7:0] e4;
    int d;

    vt[0]  = '{oh(1),  2'd0, 3'd3, 8'd0,   {8'hB0, 8'hBF, 8'hC0, 8'hC0}};
    vt[1]  = '{oh(1),  2'd0, 3'd3, 8'd47,  {8'hB0, 8'hBF, 8'h99, 8'hF8}};
    vt[2]  = '{oh(2),  2'd1, 3'd5, 8'd9,   {8'h92, 8'hA4, 8'hC0, 8'h90}};
    vt[3]  = '{18'd0,  2'd0, 3'd0, 8'd100, {8'hC0, 8'h86, 8'hC0, 8'h40}};
    vt[4]  = '{oh(6) | oh(7), 2'd0, 3'd7, 8'd255, {8'hF8, 8'h86, 8'h92, 8'h12}};
    vt[5]  = '{oh(4),  2'd0, 3'd1, 8'd99,  {8'hF9, 8'hC7, 8'h90, 8'h90}};
    vt[6]  = '{oh(5),  2'd0, 3'd2, 8'd10,  {8'hA4, 8'hC1, 8'hF9, 8'hC0}};
    vt[7]  = '{oh(0),  2'd0, 3'd4, 8'd63,  {8'h99, 8'hFF, 8'h82, 8'hB0}};
    vt[8]  = '{oh(13), 2'd0, 3'd6, 8'd81,  {8'h82, 8'hA4, 8'h80, 8'hF9}};
    vt[9]  = '{oh(8),  2'd0, 3'd0, 8'd200, {8'hC0, 8'hB0, 8'hC0, 8'h40}};
    vt[10] = '{oh(11), 2'd0, 3'd3, 8'd38,  {8'hB0, 8'hF9, 8'hB0, 8'h80}};
    vt[11] = '{oh(2),  2'd3, 3'd1, 8'd5,   {8'hF9, 8'h99, 8'hC0, 8'h92}};

    // Reset asserted mid-scan, then released into IDLE / lives 3 / minutes 0.
    state = oh(1); lives = 3'd3; minutes = 8'd0;
    tick(); tick();
    Reset = 1'b1;
    repeat (6) tick();
    Reset = 1'b0;
    #1;
    check("rst an", {4'h0, An}, 8'h0F);
    check("rst seg", Seg, 8'hFF);
    tick();
    check("rst an held", {4'h0, An}, 8'h0F);
    check("rst seg held", Seg, 8'hFF);
    Reset = 1'b1;
    for (int j = 0; j < 4 * SD; j++) begin
      tick();
      check($sformatf("scan an %0d", j), {4'h0, An}, {4'h0, an_for(j / SD)});
      if (j / SD == 2) check($sformatf("scan d2 %0d", j), Seg, 8'hBF);
      if (j / SD == 3) check($sformatf("scan d3 %0d", j), Seg, 8'hB0);
    end

    // Conversion latency: old digits through cycle 10, new ones afterwards.
    minutes = 8'd47;
    for (int j = 1; j <= 24; j++) begin
      tick();
      if (An == an_for(1)) check($sformatf("lat tens j%0d", j), Seg, (j <= 10) ? 8'hC0 : 8'h99);
      if (An == an_for(0)) check($sformatf("lat ones j%0d", j), Seg, (j <= 10) ? 8'hC0 : 8'hF8);
    end

    for (int v = 0; v < 12; v++) begin
      state = vt[v].st; game_cnt = vt[v].gc; lives = vt[v].lv; minutes = vt[v].mn;
      repeat (24) tick();
      push4(vt[v].e);
      drain($sformatf("vec%0d", v));
    end

    // Minutes change while the converter is shifting: replay with 120.
    state = oh(1); lives = 3'd3; minutes = 8'd119;
    tick(); tick(); tick();
    minutes = 8'd120;
    repeat (30) tick();
    sb.push_back('{d: 2'd0, seg: 8'h40});
    sb.push_back('{d: 2'd1, seg: 8'hA4});
    drain("pend");

    // Professor alert in GAME with game_cnt=1.
    state = oh(2); game_cnt = 2'd1; lives = 3'd2; minutes = 8'd47;
    repeat (30) tick();
    e4 = {8'hA4, 8'hA4, 8'h99, 8'hF8};
    professor = 1'b1;
    blink_window("prof", e4);
    professor = 1'b0;
    repeat (3) tick();
    steady("prof fall", e4, 20);

    // QUIZ blinks on its own; LOSE is steady.
    state = oh(3);
    e4 = {8'hA4, 8'h98, 8'h99, 8'hF8};
    blink_window("quiz", e4);
    state = oh(4);
    repeat (3) tick();
    e4 = {8'hA4, 8'hC7, 8'h99, 8'hF8};
    steady("lose", e4, 40);

    d = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fpsr_ssd_status.md
# fpsr_ssd_status

Player-facing status display for the first-person-second-row game. It reads the game controller's one-hot state vector, lives, elapsed minutes and professor alert, and drives the board's 4-digit multiplexed seven-segment display. It is the consuming end of the controller's status interface: the controller writes these status values, and this block reads, converts, scans and blinks them. Minutes go through a sequential binary-to-BCD converter, so the block has a converter handshake, a scan counter and a blink timer.

## Interface
- SCAN_DIV, 100000: clock cycles each digit stays lit (≥2).
- BLINK_DIV, 25000000: clock cycles per blink half-period (≥2).
- Clk in 1: system clock.
- Reset in 1: reset, asynchronous and active-low (0 = reset).
- state in 18: controller one-hot state. Bit order: bit0 INI, 1 IDLE, 2 GAME, 3 QUIZ, 4 LOSE, 5 WIN, 6–8 GAME1–3, 9–11 GAME1_S1–S3, 12–14 GAME2_S1–S3, 15–17 GAME3_S1–S3.
- professor in 1: quiz alert pending.
- game_cnt in 2: games completed.
- lives in 3: remaining lives.
- minutes in 8: elapsed game minutes.
- An out 4: digit anodes, active-low. An[i] is digit i.
- Seg out 8: cathodes, active-low, ordered {Dp,g,f,e,d,c,b,a}.

## Operation
- Reset values:
  - An = 4'hF and Seg = 8'hFF (display dark).
  - Scan index 0, scan and blink counters 0, blink phase "on".
  - BCD tens and ones 0, hundreds flag 0, last-minutes register 0, converter idle.
- Digit content:
  - Digit 3: lives as a decimal glyph, 0–7.
  - Digit 2: status glyph.
  - Digit 1: minutes tens.
  - Digit 0: minutes ones. Its Dp is lit when minutes ≥ 100.
- Status glyph by state:
  - INI: blank.
  - IDLE: '-'.
  - GAME: digit game_cnt+1.
  - GAME1, GAME1_S*: '1'. GAME2 and its steps: '2'. GAME3 and its steps: '3'.
  - QUIZ: 'q'. LOSE: 'L'. WIN: 'U'.
  - Zero bits set, or more than one bit set: 'E'.
- Glyph codes:
  - Digits: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Letters and symbols: blank=FF, '-'=BF, q=98, L=C7, U=C1, E=86.
- BCD conversion:
  - Converter FSM: IDLE → SHIFT (8 shift-add-3 iterations) → DONE → IDLE.
  - A start is issued when sampled minutes ≠ last-minutes. The new value is latched as last-minutes and the operand at start.
  - Tens, ones and the hundreds flag update only in DONE.
  - If minutes changes during SHIFT, a pending flag is set. One restart happens after DONE, using the then-current value.
  - minutes 100–255 display as minutes mod 100, with Dp set.
- Blink:
  - Alert = professor | state[3].
  - While alert is high, the blink phase toggles every BLINK_DIV cycles. An off phase forces Seg = FF; An keeps scanning.
  - On a rising edge of alert, the blink counter clears and the phase is "on".
  - While alert is low, the phase is held "on".
- Scan: the scan counter wraps at SCAN_DIV−1; at wrap the scan index increments mod 4.

## Timing
- An and Seg are registered. They reflect the scan index and inputs sampled one cycle earlier.
- Each digit is active for exactly SCAN_DIV cycles. Exactly one An bit is low at any time after the first post-reset output cycle.
- BCD latency: from a minutes change to new tens/ones in the registers is 10 cycles (1 sample + 8 shifts + DONE). The displayed value follows on the next registered output of digit 0 or 1.
- Status glyph and lives are not pipelined beyond the output register, so latency is 1 cycle.
- Reset asserted mid-conversion or mid-scan: immediate return to the reset values. After release, the first conversion starts only when minutes ≠ 0.
- Simultaneous minutes change and DONE: the current result is committed, then a new start on the next cycle.

## Structure
- Shared package fpsr_pkg holds:
  - the 18-bit state localparams and bit indices;
  - the glyph constants;
  - the default SCAN_DIV and BLINK_DIV values.
- Sub-module fpsr_bin2bcd: sequential 8-bit double-dabble converter.
  - Interface: start/busy/done handshake, bin[7:0] in, hund[1:0] / tens[3:0] / ones[3:0] out.
- Top level holds the scan counter, blink timer, glyph decode and output registers.

## Test plan
All scenarios use SCAN_DIV=4 and BLINK_DIV=16.
- Reset low mid-scan, then state=IDLE, lives=3, minutes=0, released → An=F, Seg=FF during reset; after release, digit2 shows BF, digit3 shows B0, and An cycles E,D,B,7 every 4 cycles.
- minutes steps 0→47 → 10 cycles later digit1 = 99, digit0 = F8, Dp off.
- minutes 119, then 120 two cycles after the start → pending restart; final display is tens A4, ones C0, Dp lit (digit0 Seg = 40).
- professor rises in state GAME with game_cnt=1 → digit2 glyph A4; Seg = FF for cycles 16–31 after the edge; normal digits return at cycle 32; steady display once professor falls.
- state=18'b0 → digit2 = 86. state = GAME1 | GAME2 → digit2 = 86.
- state = QUIZ, professor=0 → digit2 = 98 and blinking active. Then state = LOSE → digit2 = C7 with no blanking.
